// File: rtl/serv_rf_ram_bridge_if.sv
// RAM-side port bundle of the serial RF bridge: one write port, one read port.
// The bridge uses the master modport, the RAM macro the slave modport.
interface serv_rf_ram_bridge_if #(
   parameter int W        = 1,
   parameter int CSR_REGS = 4
);
   localparam int RGW = (CSR_REGS == 4) ? 6 : 5;
   localparam int CW  = $clog2(16 / W);
   localparam int RAW = RGW + CW;

   logic [RAW-1:0] o_waddr;
   logic [2*W-1:0] o_wdata;
   logic           o_wen;
   logic [RAW-1:0] o_raddr;
   logic           o_ren;
   logic [2*W-1:0] i_rdata;

   modport master (
      output o_waddr,
      output o_wdata,
      output o_wen,
      output o_raddr,
      output o_ren,
      input  i_rdata
   );

   modport slave (
      input  o_waddr,
      input  o_wdata,
      input  o_wen,
      input  o_raddr,
      input  o_ren,
      output i_rdata
   );
endinterface

// File: rtl/serv_rf_ram_bridge.sv
// Serial RF ports of the core mapped onto one 2W-bit simple dual-port RAM.
// Optional macro SERV_RF_X0_ZERO_EN: x0 reads as zero and is never written.
module serv_rf_ram_bridge #(
   parameter int  W        = 1,
   parameter int  CSR_REGS = 4,
   localparam int RGW      = (CSR_REGS == 4) ? 6 : 5,
   localparam int CW       = $clog2(16 / W),
   localparam int NCH      = 32 / W
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_rreq,
   output logic                 o_ready,
   input  logic [RGW-1:0]       i_rreg0,
   input  logic [RGW-1:0]       i_rreg1,
   output logic [W-1:0]         o_rdata0,
   output logic [W-1:0]         o_rdata1,
   input  logic [RGW-1:0]       i_wreg0,
   input  logic [RGW-1:0]       i_wreg1,
   input  logic                 i_wen0,
   input  logic                 i_wen1,
   input  logic [W-1:0]         i_wdata0,
   input  logic [W-1:0]         i_wdata1,
   serv_rf_ram_bridge_if.master ram
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_e;

   localparam logic [4:0] RC_LAST = 5'(NCH - 1);

   state_e         state_q, state_d;
   logic [4:0]     rc_q, rc_d;
   logic           dc_q, dc_d;
   logic           ready_q, ready_d;
   logic           ren_q, ren_d;
   logic           rsel_q, rsel_d;
   logic           odd_q, odd_d;
   logic [2*W-1:0] rbuf0_q, rbuf0_d;
   logic [W-1:0]   rbuf1_q, rbuf1_d;
   logic           even;

   logic [CW:0]    wc_q, wc_d;
   logic [W-1:0]   lo0_q, lo0_d;
   logic [W-1:0]   lo1_q, lo1_d;
   logic           wen0_q, wen0_d;
   logic           wen1_q, wen1_d;
   logic           pwen_q, pwen_d;
   logic [RGW-1:0] preg_q, preg_d;
   logic [CW-1:0]  pword_q, pword_d;
   logic [2*W-1:0] pdata_q, pdata_d;
   logic           wact;
   logic           wodd;
   logic [RGW-1:0] wreg;

   // Read sequencer: the rc=0 access is issued from IDLE in the request cycle.
   always_comb begin
      state_d   = state_q;
      rc_d      = rc_q;
      dc_d      = dc_q;
      ready_d   = 1'b0;
      ram.o_ren = 1'b0;
      ram.o_raddr = {i_rreg0, {CW{1'b0}}};
      case (state_q)
         IDLE: begin
            ram.o_ren = i_rreq;
            if (i_rreq) begin
               state_d = READ;
               rc_d    = 5'd1;
               ready_d = 1'b1;
            end
         end
         READ: begin
            ram.o_ren   = 1'b1;
            ram.o_raddr = {rc_q[0] ? i_rreg1 : i_rreg0, rc_q[CW:1]};
            rc_d        = rc_q + 5'd1;
            if (rc_q == RC_LAST) begin
               state_d = DRAIN;
               rc_d    = '0;
               dc_d    = 1'b0;
            end
         end
         DRAIN: begin
            dc_d = 1'b1;
            if (dc_q) begin
               state_d = IDLE;
               dc_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // even: port-1 word on i_rdata now, so chunk 2j goes out this cycle.
   always_comb begin
      even    = ren_q & rsel_q;
      ren_d   = ram.o_ren;
      rsel_d  = (state_q == READ) & rc_q[0];
      odd_d   = even;
      rbuf0_d = (ren_q & ~rsel_q) ? ram.i_rdata : rbuf0_q;
      rbuf1_d = even ? ram.i_rdata[2*W-1:W] : rbuf1_q;
   end

   always_comb begin
      o_rdata0 = '0;
      o_rdata1 = '0;
      if (even) begin
         o_rdata0 = rbuf0_q[W-1:0];
         o_rdata1 = ram.i_rdata[W-1:0];
      end else if (odd_q) begin
         o_rdata0 = rbuf0_q[2*W-1:W];
         o_rdata1 = rbuf1_q;
      end
`ifdef SERV_RF_X0_ZERO_EN
      if (i_rreg0 == '0) o_rdata0 = '0;
      if (i_rreg1 == '0) o_rdata1 = '0;
`endif
   end

   assign o_ready = ready_q;

   // Port 0 writes on odd chunks; port 1 follows one cycle later.
   always_comb begin
      wact    = i_wen0 | i_wen1;
      wodd    = wact & wc_q[0];
      wc_d    = wact ? wc_q + 1'b1 : wc_q;
      lo0_d   = lo0_q;
      lo1_d   = lo1_q;
      wen0_d  = wen0_q;
      wen1_d  = wen1_q;
      preg_d  = preg_q;
      pword_d = pword_q;
      pdata_d = pdata_q;
      pwen_d  = wodd & wen1_q;
      if (wact & ~wc_q[0]) begin
         lo0_d  = i_wdata0;
         lo1_d  = i_wdata1;
         wen0_d = i_wen0;
         wen1_d = i_wen1;
      end
      if (wodd) begin
         preg_d  = i_wreg1;
         pword_d = wc_q[CW:1];
         pdata_d = {i_wdata1, lo1_q};
      end
   end

   always_comb begin
      if (wodd) begin
         ram.o_wen   = wen0_q;
         ram.o_waddr = {i_wreg0, wc_q[CW:1]};
         ram.o_wdata = {i_wdata0, lo0_q};
         wreg        = i_wreg0;
      end else begin
         ram.o_wen   = pwen_q;
         ram.o_waddr = {preg_q, pword_q};
         ram.o_wdata = pdata_q;
         wreg        = preg_q;
      end
`ifdef SERV_RF_X0_ZERO_EN
      if (wreg == '0) ram.o_wen = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         rc_q    <= '0;
         dc_q    <= 1'b0;
         ready_q <= 1'b0;
         ren_q   <= 1'b0;
         rsel_q  <= 1'b0;
         odd_q   <= 1'b0;
         rbuf0_q <= '0;
         rbuf1_q <= '0;
         wc_q    <= '0;
         lo0_q   <= '0;
         lo1_q   <= '0;
         wen0_q  <= 1'b0;
         wen1_q  <= 1'b0;
         pwen_q  <= 1'b0;
         preg_q  <= '0;
         pword_q <= '0;
         pdata_q <= '0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         dc_q    <= dc_d;
         ready_q <= ready_d;
         ren_q   <= ren_d;
         rsel_q  <= rsel_d;
         odd_q   <= odd_d;
         rbuf0_q <= rbuf0_d;
         rbuf1_q <= rbuf1_d;
         wc_q    <= wc_d;
         lo0_q   <= lo0_d;
         lo1_q   <= lo1_d;
         wen0_q  <= wen0_d;
         wen1_q  <= wen1_d;
         pwen_q  <= pwen_d;
         preg_q  <= preg_d;
         pword_q <= pword_d;
         pdata_q <= pdata_d;
      end
   end

   logic unused_wreg;
   assign unused_wreg = ^wreg;

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// Directed bench for serv_rf_ram_bridge: W=1 and W=4 instances with RAM models.
// Build with SERV_RF_X0_ZERO_EN to exercise the x0 suppression variant.
module tb_serv_rf_ram_bridge;

`ifdef SERV_RF_X0_ZERO_EN
   localparam bit X0Z = 1'b1;
`else
   localparam bit X0Z = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic preload;
   int   checks = 0;
   int   errors = 0;

   logic       a_rreq, a_ready, a_wen0, a_wen1;
   logic [5:0] a_rreg0, a_rreg1, a_wreg0, a_wreg1;
   logic [0:0] a_rdata0, a_rdata1, a_wdata0, a_wdata1;

   logic       b_rreq, b_ready, b_wen0, b_wen1;
   logic [5:0] b_rreg0, b_rreg1, b_wreg0, b_wreg1;
   logic [3:0] b_rdata0, b_rdata1, b_wdata0, b_wdata1;

   serv_rf_ram_bridge_if #(.W(1), .CSR_REGS(4)) ram_a ();
   serv_rf_ram_bridge_if #(.W(4), .CSR_REGS(4)) ram_b ();

   serv_rf_ram_bridge #(.W(1), .CSR_REGS(4)) dut_a (
      .clk(clk), .i_rst(rst), .i_rreq(a_rreq), .o_ready(a_ready),
      .i_rreg0(a_rreg0), .i_rreg1(a_rreg1),
      .o_rdata0(a_rdata0), .o_rdata1(a_rdata1),
      .i_wreg0(a_wreg0), .i_wreg1(a_wreg1),
      .i_wen0(a_wen0), .i_wen1(a_wen1),
      .i_wdata0(a_wdata0), .i_wdata1(a_wdata1),
      .ram(ram_a)
   );

   serv_rf_ram_bridge #(.W(4), .CSR_REGS(4)) dut_b (
      .clk(clk), .i_rst(rst), .i_rreq(b_rreq), .o_ready(b_ready),
      .i_rreg0(b_rreg0), .i_rreg1(b_rreg1),
      .o_rdata0(b_rdata0), .o_rdata1(b_rdata1),
      .i_wreg0(b_wreg0), .i_wreg1(b_wreg1),
      .i_wen0(b_wen0), .i_wen1(b_wen1),
      .i_wdata0(b_wdata0), .i_wdata1(b_wdata1),
      .ram(ram_b)
   );

   logic [1:0] mem_a [0:1023];
   logic [7:0] mem_b [0:255];

   // RAM models; x0 of the W=1 RAM is preloaded with all ones.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem_a[i] <= (i < 16) ? 2'b11 : 2'b00;
         for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
      end else begin
         if (ram_a.o_wen) mem_a[ram_a.o_waddr] <= ram_a.o_wdata;
         if (ram_b.o_wen) mem_b[ram_b.o_waddr] <= ram_b.o_wdata;
      end
      if (ram_a.o_ren) ram_a.i_rdata <= mem_a[ram_a.o_raddr];
      if (ram_b.o_ren) ram_b.i_rdata <= mem_b[ram_b.o_raddr];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_a(input logic [5:0] r0, input logic [31:0] v0,
                          input bit e0, input logic [5:0] r1,
                          input logic [31:0] v1, input bit e1);
      bit         ew;
      logic [9:0] ea;
      logic [1:0] ed;
      for (int k = 0; k < 34; k++) begin
         a_wreg0  = r0;
         a_wreg1  = r1;
         a_wen0   = (k < 32) && e0;
         a_wen1   = (k < 32) && e1;
         a_wdata0 = 1'b0;
         a_wdata1 = 1'b0;
         if (k < 32) begin
            a_wdata0 = v0[k];
            a_wdata1 = v1[k];
         end
         ew = 1'b0;
         ea = '0;
         ed = '0;
         if (k < 32 && k[0]) begin
            ew = e0 && !(X0Z && r0 == 6'd0);
            ea = {r0, 4'(k >> 1)};
            ed = {v0[k], v0[k-1]};
         end else if (k > 0 && k <= 32 && !k[0]) begin
            ew = e1 && !(X0Z && r1 == 6'd0);
            ea = {r1, 4'((k - 1) >> 1)};
            ed = {v1[k-1], v1[k-2]};
         end
         #1;
         chk($sformatf("wr_wen[%0d]", k), ram_a.o_wen, ew);
         if (ew) begin
            chk($sformatf("wr_addr[%0d]", k), ram_a.o_waddr, ea);
            chk($sformatf("wr_data[%0d]", k), ram_a.o_wdata, ed);
         end
         step();
      end
      a_wen0 = 1'b0;
      a_wen1 = 1'b0;
   endtask

   task automatic read_a(input logic [5:0] r0, input logic [5:0] r1,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input bit repulse);
      logic [31:0] g0, g1;
      int          nready, nren;
      g0     = '0;
      g1     = '0;
      nready = 0;
      nren   = 0;
      a_rreg0 = r0;
      a_rreg1 = r1;
      for (int c = 0; c <= 34; c++) begin
         a_rreq = (c == 0) || (repulse && c == 10);
         #1;
         nready += int'(a_ready);
         nren   += int'(ram_a.o_ren);
         if (c == 0) begin
            chk("rd_ren_t0", ram_a.o_ren, 1'b1);
            chk("rd_raddr_t0", ram_a.o_raddr, {r0, 4'd0});
         end
         if (c == 1) begin
            chk("rd_ready_t1", a_ready, 1'b1);
            chk("rd_raddr_t1", ram_a.o_raddr, {r1, 4'd0});
         end
         if (c == 1 || c == 34) begin
            chk($sformatf("rd_idle0_c%0d", c), a_rdata0, 1'b0);
            chk($sformatf("rd_idle1_c%0d", c), a_rdata1, 1'b0);
         end
         if (c >= 2 && c <= 33) begin
            g0[c-2] = a_rdata0[0];
            g1[c-2] = a_rdata1[0];
         end
         step();
      end
      a_rreq = 1'b0;
      chk("rd_ready_cnt", 64'(nready), 64'd1);
      chk("rd_ren_cnt", 64'(nren), 64'd32);
      chk("rd_data0", g0, e0);
      chk("rd_data1", g1, e1);
   endtask

   logic [31:0] vb, gb;

   initial begin
      rst = 1'b1;
      preload = 1'b1;
      a_rreq = 0; a_rreg0 = 0; a_rreg1 = 0; a_wreg0 = 0; a_wreg1 = 0;
      a_wen0 = 0; a_wen1 = 0; a_wdata0 = 0; a_wdata1 = 0;
      b_rreq = 0; b_rreg0 = 0; b_rreg1 = 0; b_wreg0 = 0; b_wreg1 = 0;
      b_wen0 = 0; b_wen1 = 0; b_wdata0 = 0; b_wdata1 = 0;
      step();
      preload = 1'b0;
      step();
      chk("rst_ready", a_ready, 1'b0);
      chk("rst_ren", ram_a.o_ren, 1'b0);
      chk("rst_wen", ram_a.o_wen, 1'b0);
      chk("rst_rdata0", a_rdata0, 1'b0);
      chk("rst_rdata1", a_rdata1, 1'b0);
      chk("rst_b_wen", ram_b.o_wen, 1'b0);
      rst = 1'b0;
      step();

      write_a(6'd5, 32'hDEADBEEF, 1'b1, 6'd0, 32'h0, 1'b0);
      chk("x5_word0", mem_a[{6'd5, 4'd0}], 2'b11);
      read_a(6'd5, 6'd0, 32'hDEADBEEF, X0Z ? 32'h0 : 32'hFFFFFFFF, 1'b0);

      write_a(6'd3, 32'h12345678, 1'b1, 6'd34, 32'h80000000, 1'b1);
      read_a(6'd3, 6'd34, 32'h12345678, 32'h80000000, 1'b0);
      read_a(6'd34, 6'd3, 32'h80000000, 32'h12345678, 1'b1);

      a_rreg0 = 6'd5;
      a_rreg1 = 6'd3;
      a_rreq = 1'b1;
      step();
      a_rreq = 1'b0;
      repeat (11) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("abort_ready", a_ready, 1'b0);
      chk("abort_ren", ram_a.o_ren, 1'b0);
      chk("abort_wen", ram_a.o_wen, 1'b0);
      chk("abort_rdata0", a_rdata0, 1'b0);
      chk("abort_rdata1", a_rdata1, 1'b0);
      step();
      read_a(6'd5, 6'd3, 32'hDEADBEEF, 32'h12345678, 1'b0);

`ifdef SERV_RF_X0_ZERO_EN
      write_a(6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b1);
`endif
      read_a(6'd0, 6'd5, X0Z ? 32'h0 : 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0);

      vb = 32'hA5A5A5A5;
      for (int k = 0; k < 10; k++) begin
         b_wreg0  = 6'd31;
         b_wreg1  = 6'd0;
         b_wen0   = (k < 8);
         b_wdata0 = 4'h0;
         if (k < 8) b_wdata0 = vb[4*k +: 4];
         #1;
         if (k < 8 && k[0]) begin
            chk($sformatf("b_wen[%0d]", k), ram_b.o_wen, 1'b1);
            chk($sformatf("b_waddr[%0d]", k), ram_b.o_waddr, {6'd31, 2'(k >> 1)});
            chk($sformatf("b_wdata[%0d]", k), ram_b.o_wdata,
                {vb[4*k +: 4], vb[4*(k-1) +: 4]});
         end else begin
            chk($sformatf("b_wen[%0d]", k), ram_b.o_wen, 1'b0);
         end
         step();
      end
      b_wen0 = 1'b0;
      for (int j = 0; j < 4; j++)
         chk($sformatf("b_mem[%0d]", j), mem_b[{6'd31, 2'(j)}], 8'hA5);

      gb = '0;
      b_rreg0 = 6'd31;
      b_rreg1 = 6'd0;
      for (int c = 0; c <= 10; c++) begin
         b_rreq = (c == 0) || (c == 9) || (c == 10);
         #1;
         if (c == 0) begin
            chk("b_ren_t0", ram_b.o_ren, 1'b1);
            chk("b_raddr_t0", ram_b.o_raddr, {6'd31, 2'd0});
         end
         if (c == 1) chk("b_ready_t1", b_ready, 1'b1);
         if (c >= 2 && c <= 9) gb[4*(c-2) +: 4] = b_rdata0;
         if (c == 9) chk("b_drain_ren", ram_b.o_ren, 1'b0);
         if (c == 10) begin
            chk("b_idle_ren", ram_b.o_ren, 1'b1);
            chk("b_idle_ready", b_ready, 1'b0);
         end
         step();
      end
      b_rreq = 1'b0;
      chk("b_rdata0", gb, 32'hA5A5A5A5);
      repeat (14) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
